// File: rtl/fsm_table_loader_pkg.sv
// fsm_pkg: shared types for the table-driven FSM and its table loader.
// Holds table/entry types, the write-word bundle, loader states and CRC constants.
package fsm_pkg;

  localparam int DEF_STATES = 16;
  localparam int DEF_INPUTS = 8;
  localparam int DEF_PRIO_W = 8;
  localparam int DEF_SW     = $clog2(DEF_STATES);
  localparam int DEF_IW     = $clog2(DEF_INPUTS);
  localparam int DEF_ENTRIES = DEF_STATES * DEF_INPUTS;

  typedef struct packed {
    logic [DEF_SW-1:0]     next;
    logic [DEF_PRIO_W-1:0] prio;
    logic                  sige;
  } state_entry_t;

  typedef state_entry_t [DEF_ENTRIES-1:0] state_table_t;

  typedef struct packed {
    logic [DEF_SW-1:0]     st;
    logic [DEF_IW-1:0]     inp;
    logic [DEF_SW-1:0]     nxt;
    logic [DEF_PRIO_W-1:0] prio;
    logic                  sige;
  } fsm_tbl_wr_t;

  typedef enum logic [1:0] {
    LD_IDLE   = 2'd0,
    LD_LOAD   = 2'd1,
    LD_COMMIT = 2'd2
  } ld_state_e;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

endpackage

// File: rtl/fsm_table_loader_if.sv
// fsm_table_loader_if: valid/ready write stream carrying one table entry per beat.
// The bridge drives the master side; the loader is the slave.
interface fsm_table_loader_if
  import fsm_pkg::*;
#(
  parameter int SW     = DEF_SW,
  parameter int IW     = DEF_IW,
  parameter int PRIO_W = DEF_PRIO_W
);

  logic              wr_valid;
  logic              wr_ready;
  logic [SW-1:0]     wr_state;
  logic [IW-1:0]     wr_input;
  logic [SW-1:0]     wr_next;
  logic [PRIO_W-1:0] wr_prio;
  logic              wr_sige;

  modport master (
    output wr_valid, wr_state, wr_input,
    output wr_next, wr_prio, wr_sige,
    input  wr_ready
  );

  modport slave (
    input  wr_valid, wr_state, wr_input,
    input  wr_next, wr_prio, wr_sige,
    output wr_ready
  );

endinterface

// File: rtl/fsm_table_loader_crc.sv
// fsm_tbl_crc16: CRC-16/CCITT over one WW-bit word per cycle, MSB first.
// clr reloads the init value; en folds the presented word in.
module fsm_tbl_crc16
  import fsm_pkg::*;
#(
  parameter int WW = 20
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic [WW-1:0] word,
  output logic [15:0]   crc
);

  logic [15:0] crc_q, crc_d, nxt;

  always_comb begin
    nxt = crc_q;
    for (int b = WW - 1; b >= 0; b--) begin
      if (nxt[15] ^ word[b])
        nxt = {nxt[14:0], 1'b0} ^ CRC_POLY;
      else
        nxt = {nxt[14:0], 1'b0};
    end
    crc_d = crc_q;
    if (clr)
      crc_d = CRC_INIT;
    else if (en)
      crc_d = nxt;
  end

  always_ff @(posedge clk) begin
    if (rst)
      crc_q <= CRC_INIT;
    else
      crc_q <= crc_d;
  end

  assign crc = crc_q;

endmodule

// File: rtl/fsm_table_loader.sv
// fsm_table_loader: builds a shadow transition table and commits it atomically.
// Define FSM_TBL_CRC_EN to add cmd_crc and a CRC-16 gate on commit.
module fsm_table_loader
  import fsm_pkg::*;
#(
  parameter int STATES = DEF_STATES,
  parameter int INPUTS = DEF_INPUTS,
  parameter int PRIO_W = DEF_PRIO_W,
  localparam int SW = $clog2(STATES),
  localparam int IW = $clog2(INPUTS),
  localparam int E  = STATES * INPUTS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_start,
  input  logic                cmd_commit,
  input  logic                cmd_abort,
`ifdef FSM_TBL_CRC_EN
  input  logic [15:0]         cmd_crc,
`endif
  fsm_table_loader_if.slave   wr,
  output logic [E*SW-1:0]     tbl_next,
  output logic [E*PRIO_W-1:0] tbl_prio,
  output logic [E-1:0]        tbl_sige,
  output logic                busy,
  output logic [15:0]         word_cnt,
  output logic                err_range,
  output logic                commit_done,
  output logic                commit_fail,
  output logic [7:0]          tbl_gen
);

  localparam int XW = $clog2(E);
  localparam int WW = 2 * SW + IW + PRIO_W + 1;

  ld_state_e state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  gen_q, gen_d;
  logic        err_q, err_d;
  logic        done_q, done_d;
  logic        fail_q, fail_d;

  logic [SW-1:0]     sh_next_q [E], sh_next_d [E];
  logic [PRIO_W-1:0] sh_prio_q [E], sh_prio_d [E];
  logic              sh_sige_q [E], sh_sige_d [E];
  logic [SW-1:0]     act_next_q [E], act_next_d [E];
  logic [PRIO_W-1:0] act_prio_q [E], act_prio_d [E];
  logic              act_sige_q [E], act_sige_d [E];

  logic          hs, in_rng, crc_bad;
  logic [XW-1:0] idx;

  assign wr.wr_ready = (state_q == LD_LOAD);
  assign hs = wr.wr_valid && wr.wr_ready;
  // Widen by one bit so the bound also works when STATES is a power of 2
  assign in_rng = ({1'b0, wr.wr_state} < (SW+1)'(STATES))
               && ({1'b0, wr.wr_next} < (SW+1)'(STATES))
               && ({1'b0, wr.wr_input} < (IW+1)'(INPUTS));
  assign idx = XW'(wr.wr_state) * XW'(INPUTS) + XW'(wr.wr_input);

`ifdef FSM_TBL_CRC_EN
  logic [15:0] crc_q, crc_exp_q, crc_exp_d;
  logic        crc_clr, crc_en;

  assign crc_clr = (state_q == LD_IDLE) && cmd_start;
  assign crc_en  = (state_q == LD_LOAD) && hs && in_rng && !cmd_abort;
  assign crc_exp_d = (state_q == LD_LOAD && cmd_commit) ? cmd_crc : crc_exp_q;
  assign crc_bad = (crc_q != crc_exp_q);

  fsm_tbl_crc16 #(.WW(WW)) u_crc (
    .clk  (clk),
    .rst  (rst),
    .clr  (crc_clr),
    .en   (crc_en),
    .word ({wr.wr_state, wr.wr_input, wr.wr_next,
            wr.wr_prio, wr.wr_sige}),
    .crc  (crc_q)
  );

  always_ff @(posedge clk) begin
    if (rst)
      crc_exp_q <= '0;
    else
      crc_exp_q <= crc_exp_d;
  end
`else
  assign crc_bad = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    gen_d      = gen_q;
    err_d      = err_q;
    done_d     = 1'b0;
    fail_d     = 1'b0;
    sh_next_d  = sh_next_q;
    sh_prio_d  = sh_prio_q;
    sh_sige_d  = sh_sige_q;
    act_next_d = act_next_q;
    act_prio_d = act_prio_q;
    act_sige_d = act_sige_q;
    case (state_q)
      LD_IDLE: begin
        if (cmd_start) begin
          state_d   = LD_LOAD;
          sh_next_d = act_next_q;
          sh_prio_d = act_prio_q;
          sh_sige_d = act_sige_q;
          cnt_d     = '0;
          err_d     = 1'b0;
        end
      end
      LD_LOAD: begin
        if (cmd_abort) begin
          state_d = LD_IDLE;
        end else begin
          if (hs && in_rng) begin
            sh_next_d[idx] = wr.wr_next;
            sh_prio_d[idx] = wr.wr_prio;
            sh_sige_d[idx] = wr.wr_sige;
            if (cnt_q != 16'hFFFF)
              cnt_d = cnt_q + 16'd1;
          end else if (hs) begin
            err_d = 1'b1;
          end
          if (cmd_commit)
            state_d = LD_COMMIT;
        end
      end
      LD_COMMIT: begin
        state_d = LD_IDLE;
        if (err_q || crc_bad) begin
          fail_d = 1'b1;
        end else begin
          act_next_d = sh_next_q;
          act_prio_d = sh_prio_q;
          act_sige_d = sh_sige_q;
          gen_d      = gen_q + 8'd1;
          done_d     = 1'b1;
        end
      end
      default: state_d = LD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= LD_IDLE;
      cnt_q      <= '0;
      gen_q      <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      fail_q     <= 1'b0;
      sh_next_q  <= '{default: '0};
      sh_prio_q  <= '{default: '0};
      sh_sige_q  <= '{default: '0};
      act_next_q <= '{default: '0};
      act_prio_q <= '{default: '0};
      act_sige_q <= '{default: '0};
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gen_q      <= gen_d;
      err_q      <= err_d;
      done_q     <= done_d;
      fail_q     <= fail_d;
      sh_next_q  <= sh_next_d;
      sh_prio_q  <= sh_prio_d;
      sh_sige_q  <= sh_sige_d;
      act_next_q <= act_next_d;
      act_prio_q <= act_prio_d;
      act_sige_q <= act_sige_d;
    end
  end

  always_comb begin
    tbl_next = '0;
    tbl_prio = '0;
    tbl_sige = '0;
    for (int k = 0; k < E; k++) begin
      tbl_next[k*SW +: SW]         = act_next_q[k];
      tbl_prio[k*PRIO_W +: PRIO_W] = act_prio_q[k];
      tbl_sige[k]                  = act_sige_q[k];
    end
  end

  assign busy        = (state_q != LD_IDLE);
  assign word_cnt    = cnt_q;
  assign err_range   = err_q;
  assign commit_done = done_q;
  assign commit_fail = fail_q;
  assign tbl_gen     = gen_q;

endmodule

// File: tb/tb_fsm_table_loader.sv
// tb_fsm_table_loader: directed + randomized sessions against a table model.
// STATES=12 so out-of-range state/next values are representable in 4 bits.
module tb_fsm_table_loader;

  localparam int ST = 12;
  localparam int IN = 8;
  localparam int PW = 8;
  localparam int E  = ST * IN;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_start = 1'b0;
  logic cmd_commit = 1'b0;
  logic cmd_abort = 1'b0;
  logic [15:0] cmd_crc = 16'h0;
  logic [E*4-1:0]  tbl_next;
  logic [E*PW-1:0] tbl_prio;
  logic [E-1:0]    tbl_sige;
  logic        busy, err_range, commit_done, commit_fail;
  logic [15:0] word_cnt;
  logic [7:0]  tbl_gen;

  int n_tests = 0;
  int n_fail = 0;

  int m_act_n [E];
  int m_act_p [E];
  int m_act_g [E];
  int m_sh_n [E];
  int m_sh_p [E];
  int m_sh_g [E];
  int m_gen = 0;
  int m_cnt = 0;
  bit m_err = 1'b0;
  logic [15:0] m_crc = 16'hFFFF;

`ifdef FSM_TBL_CRC_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif

  fsm_table_loader_if #(.SW(4), .IW(3), .PRIO_W(PW)) wif ();

  fsm_table_loader #(.STATES(ST), .INPUTS(IN), .PRIO_W(PW)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_start   (cmd_start),
    .cmd_commit  (cmd_commit),
    .cmd_abort   (cmd_abort),
`ifdef FSM_TBL_CRC_EN
    .cmd_crc     (cmd_crc),
`endif
    .wr          (wif),
    .tbl_next    (tbl_next),
    .tbl_prio    (tbl_prio),
    .tbl_sige    (tbl_sige),
    .busy        (busy),
    .word_cnt    (word_cnt),
    .err_range   (err_range),
    .commit_done (commit_done),
    .commit_fail (commit_fail),
    .tbl_gen     (tbl_gen)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_tbl(input string tag);
    logic [E*4-1:0]  en;
    logic [E*PW-1:0] ep;
    logic [E-1:0]    eg;
    for (int k = 0; k < E; k++) begin
      en[k*4 +: 4]   = 4'(m_act_n[k]);
      ep[k*PW +: PW] = 8'(m_act_p[k]);
      eg[k]          = 1'(m_act_g[k]);
    end
    n_tests++;
    assert (tbl_next === en) else begin
      n_fail++;
      $error("FAIL %s_next: observed %0h expected %0h", tag, tbl_next, en);
    end
    n_tests++;
    assert (tbl_prio === ep) else begin
      n_fail++;
      $error("FAIL %s_prio: observed %0h expected %0h", tag, tbl_prio, ep);
    end
    n_tests++;
    assert (tbl_sige === eg) else begin
      n_fail++;
      $error("FAIL %s_sige: observed %0h expected %0h", tag, tbl_sige, eg);
    end
  endtask

  function automatic logic [15:0] crc_upd(input logic [15:0] c,
                                          input logic [19:0] w);
    logic [15:0] r;
    logic fb;
    r = c;
    for (int b = 19; b >= 0; b--) begin
      fb = r[15] ^ w[b];
      r = {r[14:0], 1'b0};
      if (fb) r = r ^ 16'h1021;
    end
    return r;
  endfunction

  task automatic m_reset();
    for (int k = 0; k < E; k++) begin
      m_act_n[k] = 0; m_act_p[k] = 0; m_act_g[k] = 0;
      m_sh_n[k] = 0;  m_sh_p[k] = 0;  m_sh_g[k] = 0;
    end
    m_gen = 0; m_cnt = 0; m_err = 1'b0; m_crc = 16'hFFFF;
  endtask

  task automatic m_write(input int s, i, n, p, g);
    if (s < ST && n < ST) begin
      m_sh_n[s*IN+i] = n;
      m_sh_p[s*IN+i] = p;
      m_sh_g[s*IN+i] = g;
      if (m_cnt < 65535) m_cnt++;
      m_crc = crc_upd(m_crc, {4'(s), 3'(i), 4'(n), 8'(p), 1'(g)});
    end else begin
      m_err = 1'b1;
    end
  endtask

  task automatic set_wr(input bit v, input int s, i, n, p, g);
    wif.wr_valid = v;
    wif.wr_state = 4'(s);
    wif.wr_input = 3'(i);
    wif.wr_next  = 4'(n);
    wif.wr_prio  = 8'(p);
    wif.wr_sige  = 1'(g);
  endtask

  task automatic s_start();
    cmd_start = 1'b1;
    step();
    cmd_start = 1'b0;
    m_sh_n = m_act_n; m_sh_p = m_act_p; m_sh_g = m_act_g;
    m_cnt = 0; m_err = 1'b0; m_crc = 16'hFFFF;
    chk("start_busy", busy, 1);
    chk("start_ready", wif.wr_ready, 1);
    chk("start_cnt", word_cnt, 0);
  endtask

  task automatic s_write(input int s, i, n, p, g);
    set_wr(1'b1, s, i, n, p, g);
    step();
    wif.wr_valid = 1'b0;
    m_write(s, i, n, p, g);
    chk("wr_cnt", word_cnt, 32'(m_cnt));
    chk("wr_err", err_range, {31'b0, m_err});
  endtask

  task automatic s_commit(input bit wr_too, input int s, i, n, p, g,
                          input bit bad);
    bit ok;
    if (wr_too) begin
      set_wr(1'b1, s, i, n, p, g);
      m_write(s, i, n, p, g);
    end
    cmd_commit = 1'b1;
    cmd_crc = m_crc ^ {15'b0, bad};
    step();
    cmd_commit = 1'b0;
    wif.wr_valid = 1'b0;
    chk("cm_busy", busy, 1);
    chk("cm_ready", wif.wr_ready, 0);
    chk("cm_early_done", commit_done, 0);
    ok = !m_err && !(CRC_ON && bad);
    step();
    if (ok) begin
      m_act_n = m_sh_n; m_act_p = m_sh_p; m_act_g = m_sh_g;
      m_gen = (m_gen + 1) % 256;
    end
    chk("cm_done", commit_done, {31'b0, ok});
    chk("cm_fail", commit_fail, {31'b0, !ok});
    chk("cm_gen", tbl_gen, 32'(m_gen));
    chk("cm_idle", busy, 0);
    chk("cm_cnt", word_cnt, 32'(m_cnt));
    chk("cm_err", err_range, {31'b0, m_err});
    chk_tbl("cm_tbl");
  endtask

  task automatic s_abort(input bit wr_too, input bit with_commit,
                         input int s, i, n, p, g);
    if (wr_too) set_wr(1'b1, s, i, n, p, g);
    cmd_abort = 1'b1;
    cmd_commit = with_commit;
    step();
    cmd_abort = 1'b0;
    cmd_commit = 1'b0;
    wif.wr_valid = 1'b0;
    chk("ab_idle", busy, 0);
    step();
    chk("ab_done", commit_done, 0);
    chk("ab_fail", commit_fail, 0);
    chk_tbl("ab_tbl");
  endtask

  initial begin
    int s, i, n, p, g, nw, r, guard;
    set_wr(1'b0, 0, 0, 0, 0, 0);
    m_reset();
    @(negedge clk);
    repeat (3) step();
    rst = 1'b0;
    step();

    chk("rst_gen", tbl_gen, 0);
    chk("rst_ready", wif.wr_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", word_cnt, 0);
    chk("rst_err", err_range, 0);
    chk("rst_done", commit_done, 0);
    chk_tbl("rst_tbl");

    s_start();
    s_write(3, 2, 5, 7, 1);
    s_commit(1'b0, 0, 0, 0, 0, 0, 1'b0);
    chk("e26_next", tbl_next[26*4 +: 4], 5);
    chk("e26_prio", tbl_prio[26*8 +: 8], 7);
    chk("e26_sige", tbl_sige[26], 1);
    chk("gen1", tbl_gen, 1);
    step();
    chk("done_pulse", commit_done, 0);

    s_start();
    s_write(12, 0, 1, 1, 1);
    chk("oor_err", err_range, 1);
    s_write(1, 1, 2, 3, 0);
    chk("oor_cnt", word_cnt, 1);
    s_commit(1'b0, 0, 0, 0, 0, 0, 1'b0);
    chk("oor_gen", tbl_gen, 1);

    s_start();
    s_write(0, 0, 4, 9, 1);
    s_abort(1'b0, 1'b0, 0, 0, 0, 0, 0);
    chk("ab_e0", tbl_next[3:0], 0);
    s_start();
    s_commit(1'b0, 0, 0, 0, 0, 0, 1'b0);
    chk("reload_e0", tbl_next[3:0], 0);

    s_start();
    s_commit(1'b1, 5, 1, 9, 200, 1, 1'b0);
    chk("cmwr_e41", tbl_next[41*4 +: 4], 9);
    s_start();
    s_abort(1'b1, 1'b1, 6, 3, 10, 100, 1);
    chk("abwr_e51", tbl_next[51*4 +: 4], 0);

    s_start();
    s_write(2, 2, 2, 2, 1);
    s_write(2, 2, 11, 33, 0);
    s_write(7, 4, 1, 255, 1);
    s_commit(1'b0, 0, 0, 0, 0, 0, 1'b0);
    chk("last_wins", tbl_next[18*4 +: 4], 11);
    if (CRC_ON) begin
      s_start();
      s_write(1, 0, 3, 4, 1);
      s_write(4, 7, 8, 9, 0);
      s_write(10, 5, 6, 77, 1);
      s_commit(1'b0, 0, 0, 0, 0, 0, 1'b1);
      chk("crc_bad_fail", commit_fail, 1);
    end

    for (int t = 0; t < 60; t++) begin
      s_start();
      nw = $urandom_range(0, 6);
      for (int w = 0; w < nw; w++) begin
        if ($urandom_range(0, 3) == 0) begin
          step();
          chk("idle_cnt", word_cnt, 32'(m_cnt));
        end
        s = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 3)
                                        : $urandom_range(0, ST - 1);
        n = $urandom_range(0, ST - 1);
        if ($urandom_range(0, 9) == 0) s = $urandom_range(ST, 15);
        if ($urandom_range(0, 9) == 0) n = $urandom_range(ST, 15);
        i = $urandom_range(0, 7);
        p = $urandom_range(0, 255);
        g = $urandom_range(0, 1);
        s_write(s, i, n, p, g);
      end
      s = $urandom_range(0, ST - 1);
      i = $urandom_range(0, 7);
      n = $urandom_range(0, ST - 1);
      p = $urandom_range(0, 255);
      g = $urandom_range(0, 1);
      r = $urandom_range(0, 9);
      if (r < 2)
        s_abort(1'(r), 1'($urandom_range(0, 1)), s, i, n, p, g);
      else
        s_commit(1'($urandom_range(0, 1)), s, i, n, p, g,
                 CRC_ON && ($urandom_range(0, 3) == 0));
    end

    s_start();
    s_write(9, 1, 3, 3, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_reset();
    chk("mrst_busy", busy, 0);
    chk("mrst_gen", tbl_gen, 0);
    chk_tbl("mrst_tbl");

    guard = 0;
    while (m_gen != 255 && guard < 300) begin
      s_start();
      s_commit(1'b0, 0, 0, 0, 0, 0, 1'b0);
      guard++;
    end
    chk("gen_255", tbl_gen, 255);
    s_start();
    s_commit(1'b0, 0, 0, 0, 0, 0, 1'b0);
    chk("gen_wrap", tbl_gen, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
